// File: rtl/edf_scheduler.sv
// ---------------------------------------------------------------------------
// edf_scheduler
//
// Earliest-deadline-first arbitration stage. Every cycle it picks, among the
// pending request queues, the one whose relative-deadline counter is
// smallest, and presents that choice as a registered (index, valid) pair.
// Once valid is high the choice is committed until the downstream side
// accepts it with ready. On acceptance the winning queue's counter reloads
// from its period; all other counters count down and stop at zero.
//
// Parameters
//   INPUTS         number of request queues (>= 2)
//   DEADLINE_SIZE  width of the period and deadline counters
//
// Ports
//   clock    rising-edge clock
//   reset    asynchronous, active-low reset
//   periods  per-queue relative deadline loaded on service (quasi-static)
//   pending  bit i set when queue i holds a request
//   ready    downstream accepts the current selection this cycle
//   index    selected queue, drives the downstream value selector
//   valid    index is a real selection
//   overdue  bit i set when queue i is pending and its counter is at zero
// ---------------------------------------------------------------------------
module edf_scheduler #(
    parameter int INPUTS        = 4,
    parameter int DEADLINE_SIZE = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [INPUTS-1:0][DEADLINE_SIZE-1:0]  periods,
    input  logic [INPUTS-1:0]                     pending,
    input  logic                                  ready,
    output logic [$clog2(INPUTS)-1:0]             index,
    output logic                                  valid,
    output logic [INPUTS-1:0]                     overdue
);

    localparam int IDX_W = $clog2(INPUTS);
    // The comparator tree is built over a power-of-two number of leaves;
    // leaves beyond INPUTS stay invalid and never win.
    localparam int NPOW  = 1 << IDX_W;
    localparam int NODES = 2 * NPOW - 1;

    logic [DEADLINE_SIZE-1:0] deadline_q [INPUTS];
    logic [DEADLINE_SIZE-1:0] deadline_d [INPUTS];
    logic [IDX_W-1:0]         index_q;
    logic [IDX_W-1:0]         index_d;
    logic                     valid_q;
    logic                     valid_d;

    logic                     grant;
    logic [INPUTS-1:0]        candidate;

    // Heap-ordered comparator tree: node n has children 2n+1 and 2n+2,
    // leaves sit at NPOW-1 .. 2*NPOW-2, root is node 0.
    logic                     node_vld [NODES];
    logic [DEADLINE_SIZE-1:0] node_key [NODES];
    logic [IDX_W-1:0]         node_idx [NODES];

    assign grant = valid_q & ready;

    // The queue being served on this edge must not win again on the same
    // edge, which is what keeps a lone queue from being granted back to back.
    always_comb begin
        candidate = '0;
        for (int i = 0; i < INPUTS; i++) begin
            candidate[i] = pending[i] && !(grant && (index_q == IDX_W'(i)));
        end
    end

    // Argmin over the candidates using pre-edge counter values. The left
    // child always covers lower queue numbers, so taking left on equal keys
    // resolves ties toward the lowest index.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            node_vld[n] = 1'b0;
            node_key[n] = '0;
            node_idx[n] = '0;
        end
        for (int i = 0; i < INPUTS; i++) begin
            node_vld[NPOW - 1 + i] = candidate[i];
            node_key[NPOW - 1 + i] = deadline_q[i];
            node_idx[NPOW - 1 + i] = IDX_W'(i);
        end
        for (int n = NPOW - 2; n >= 0; n--) begin
            if (node_vld[2*n+1] &&
                (!node_vld[2*n+2] || (node_key[2*n+1] <= node_key[2*n+2]))) begin
                node_vld[n] = node_vld[2*n+1];
                node_key[n] = node_key[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end else begin
                node_vld[n] = node_vld[2*n+2];
                node_key[n] = node_key[2*n+2];
                node_idx[n] = node_idx[2*n+2];
            end
        end
    end

    // Granted counter reloads instead of decrementing; the rest saturate at 0.
    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            if (grant && (index_q == IDX_W'(i))) begin
                deadline_d[i] = periods[i];
            end else if (deadline_q[i] == '0) begin
                deadline_d[i] = '0;
            end else begin
                deadline_d[i] = deadline_q[i] - DEADLINE_SIZE'(1);
            end
        end
    end

    // A presented but unaccepted selection is held even if its queue has
    // since dropped its request: the selection is committed.
    always_comb begin
        valid_d = valid_q;
        index_d = index_q;
        if (!(valid_q && !ready)) begin
            valid_d = node_vld[0];
            index_d = node_vld[0] ? node_idx[0] : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < INPUTS; i++) begin
                deadline_q[i] <= '0;
            end
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < INPUTS; i++) begin
                deadline_q[i] <= deadline_d[i];
            end
            index_q <= index_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        overdue = '0;
        for (int i = 0; i < INPUTS; i++) begin
            overdue[i] = pending[i] && (deadline_q[i] == '0);
        end
    end

    assign index = index_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_edf_scheduler.sv
// ---------------------------------------------------------------------------
// tb_edf_scheduler
//
// Directed testbench for edf_scheduler (INPUTS=4, DEADLINE_SIZE=16).
// Inputs change 1 time unit after a rising edge, outputs are sampled at the
// same point, so every sample sees the state produced by the last edge.
// Expected index/valid/overdue values are worked out by hand from the
// counter arithmetic noted next to each sequence.
// ---------------------------------------------------------------------------
module tb_edf_scheduler;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [3:0][15:0]  periods;
    logic [3:0]        pending;
    logic              ready;
    logic [1:0]        index;
    logic              valid;
    logic [3:0]        overdue;

    int check_count = 0;
    int error_count = 0;

    edf_scheduler #(
        .INPUTS        (4),
        .DEADLINE_SIZE (16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .periods (periods),
        .pending (pending),
        .ready   (ready),
        .index   (index),
        .valid   (valid),
        .overdue (overdue)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pend, input logic rdy);
        pending = pend;
        ready   = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expectState(input string tag, input logic v, input logic [1:0] idx,
                               input logic [3:0] ovd);
        checkOutput({tag, ".valid"},   32'(valid),   32'(v));
        checkOutput({tag, ".index"},   32'(index),   32'(idx));
        checkOutput({tag, ".overdue"}, 32'(overdue), 32'(ovd));
    endtask

    // Short reset pulse placed between edges.
    task automatic pulseReset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] edf_idx [6];
        logic [3:0] edf_ovd [6];

        // ---------------- Reset and EDF order ----------------
        // periods = {10,3,7,5} for queues 0..3, all queues pending.
        periods[0] = 16'd10;
        periods[1] = 16'd3;
        periods[2] = 16'd7;
        periods[3] = 16'd5;
        applyStimulus(4'b1111, 1'b0);
        #1;
        expectState("reset", 1'b0, 2'd0, 4'b1111);
        #1;
        reset = 1'b1;
        tick();
        expectState("first_edge", 1'b1, 2'd0, 4'b1111);

        // Counter trace (q0..q3) after each grant edge:
        //   [10,0,0,0] [9,3,0,0] [8,2,7,0] [7,1,6,5] [6,3,5,4] [5,2,4,5]
        edf_idx = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd1};
        edf_ovd = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            expectState($sformatf("edf_%0d", k), 1'b1, edf_idx[k], edf_ovd[k]);
        end

        // ---------------- Hold under backpressure ----------------
        pulseReset();
        applyStimulus(4'b0100, 1'b0);
        tick();
        expectState("hold_sel", 1'b1, 2'd2, 4'b0100);
        applyStimulus(4'b0001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            expectState($sformatf("hold_%0d", k), 1'b1, 2'd2, 4'b0001);
        end
        // Queue 2 requests again; its counter must still be 0 (no reload).
        applyStimulus(4'b0101, 1'b0);
        tick();
        expectState("hold_noreload", 1'b1, 2'd2, 4'b0101);
        // Accept: counter 2 reloads to 7, queue 0 is the only candidate.
        applyStimulus(4'b0101, 1'b1);
        tick();
        expectState("hold_release", 1'b1, 2'd0, 4'b0001);
        // Accept queue 0: counters become 10 and 6.
        tick();
        expectState("hold_after", 1'b1, 2'd2, 4'b0000);

        // ---------------- Sole queue ----------------
        pulseReset();
        applyStimulus(4'b1000, 1'b1);
        tick();
        expectState("sole_0", 1'b1, 2'd3, 4'b1000);
        tick();
        expectState("sole_1", 1'b0, 2'd0, 4'b0000);
        tick();
        expectState("sole_2", 1'b1, 2'd3, 4'b0000);
        tick();
        expectState("sole_3", 1'b0, 2'd0, 4'b0000);
        tick();
        expectState("sole_4", 1'b1, 2'd3, 4'b0000);

        // ---------------- Saturation and overdue ----------------
        pulseReset();
        periods[0] = 16'd10;
        periods[1] = 16'd2;
        applyStimulus(4'b0010, 1'b1);
        tick();
        expectState("sat_sel", 1'b1, 2'd1, 4'b0010);
        tick();
        expectState("sat_reload", 1'b0, 2'd0, 4'b0000);
        // Queue 0 (counter 0) beats queue 1 (counter 2) and is committed.
        applyStimulus(4'b0011, 1'b0);
        tick();
        expectState("sat_commit", 1'b1, 2'd0, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            tick();
            expectState($sformatf("sat_%0d", k), 1'b1, 2'd0, 4'b0011);
        end
        applyStimulus(4'b0011, 1'b1);
        tick();
        expectState("sat_win", 1'b1, 2'd1, 4'b0010);

        // ---------------- Tie-break and asynchronous reset ----------------
        // periods q0=1, q1=5, q2=4 so that q1 and q2 meet at 4 with q0
        // winning the edge in between.
        pulseReset();
        periods[0] = 16'd1;
        periods[1] = 16'd5;
        periods[2] = 16'd4;
        periods[3] = 16'd5;
        applyStimulus(4'b0111, 1'b0);
        tick();
        expectState("tie_start", 1'b1, 2'd0, 4'b0111);
        applyStimulus(4'b0111, 1'b1);
        tick();
        expectState("tie_a", 1'b1, 2'd1, 4'b0110);
        tick();
        expectState("tie_b", 1'b1, 2'd2, 4'b0101);
        tick();
        expectState("tie_c", 1'b1, 2'd0, 4'b0001);
        tick();
        expectState("tie_pick", 1'b1, 2'd1, 4'b0000);
        reset = 1'b0;
        #1;
        expectState("async_reset", 1'b0, 2'd0, 4'b0111);
        reset = 1'b1;
        tick();
        expectState("post_reset", 1'b1, 2'd0, 4'b0111);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
